// File: rtl/ram_pipe.sv
// -----------------------------------------------------------------------------
// ram_pipe
//
// Single-port on-chip RAM peripheral with byte-lane write enables and a
// buffered response channel. Each request returns exactly one response,
// whether it is a read or a write. The response carries read data and an
// error flag. The request side runs at one request per cycle for as long as
// the response side keeps up. A small response FIFO absorbs back-pressure, so
// rsp_ready_i never reaches req_ready_o combinationally.
//
// Parameters
//   DW         data width in bits (32 or 64); NB = DW/8 byte lanes
//   DP         depth in DW-bit words (power of two, >= 16)
//   RSP_DEPTH  response buffer entries (>= 2)
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  request ready (registered state only, 0 during reset)
//   addr_i       byte address; low log2(NB) bits ignored
//   we_i         1 = write, 0 = read
//   sel_i        byte-lane write enables (ignored for reads)
//   data_i       write data (ignored for reads)
//   rsp_valid_o  response valid
//   rsp_ready_i  response ready
//   data_o       read data (0 for writes and errors)
//   rsp_err_o    word index out of range
// -----------------------------------------------------------------------------
module ram_pipe #(
   parameter int DW        = 32,
   parameter int DP        = 4096,
   parameter int RSP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   input  logic [DW/8-1:0]   sel_i,
   input  logic [DW-1:0]     data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DW-1:0]     data_o,
   output logic              rsp_err_o
);

   localparam int NB  = DW / 8;
   localparam int OFS = $clog2(NB);
   localparam int IW  = $clog2(DP);
   localparam int PW  = $clog2(RSP_DEPTH);
   localparam int CW  = $clog2(RSP_DEPTH + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
   localparam logic [CW:0]   OUT_MAX  = (CW + 1)'(RSP_DEPTH);

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic [31:0]   word_idx;
   logic [IW-1:0] mem_idx;
   logic          addr_err;
   logic          fire;
   logic          wr_en;
   logic          rd_en;

   // The range check uses the full 32-bit word index, so aliases above the
   // array never wrap back into it.
   assign word_idx = addr_i >> OFS;
   assign mem_idx  = word_idx[IW-1:0];
   assign addr_err = (word_idx >= 32'(DP));

   assign fire  = req_valid_i & req_ready_o;
   assign wr_en = fire &  we_i & ~addr_err;
   assign rd_en = fire & ~we_i & ~addr_err;

   // ------------------------------------------------------------------------
   // Storage array and synchronous read register
   // ------------------------------------------------------------------------
   logic [DW-1:0] mem [DP];
   logic [DW-1:0] mem_q;

   // NOTE: the array and its read register have no reset on purpose; a reset
   // term would stop the tools from mapping this onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (sel_i[b]) begin
               mem[mem_idx][8*b +: 8] <= data_i[8*b +: 8];
            end
         end
      end
      // mem_q only matters for good reads; writes and errors return 0, so
      // the register simply holds otherwise.
      if (rd_en) begin
         mem_q <= mem[mem_idx];
      end
   end

   // ------------------------------------------------------------------------
   // In-flight response (the cycle right after accept)
   // ------------------------------------------------------------------------
   logic          infl;
   logic          infl_err;
   logic          infl_rd;
   logic [DW-1:0] infl_data;

   // NOTE: all clocked state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infl     <= 1'b0;
         infl_err <= 1'b0;
         infl_rd  <= 1'b0;
      end else begin
         infl <= fire;
         if (fire) begin
            infl_err <= addr_err;
            infl_rd  <= ~we_i & ~addr_err;
         end
      end
   end

   assign infl_data = infl_rd ? mem_q : '0;

   // ------------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------------
   logic [DW-1:0]        fifo_data [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] fifo_err;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [CW-1:0]        count;
   logic [CW-1:0]        count_next;
   logic [CW:0]          outstanding;

   logic fifo_empty;
   logic bypass;
   logic pop;
   logic fifo_pop;
   logic push;

   assign fifo_empty = (count == '0);

   // When nothing is queued ahead of it, the in-flight response goes straight
   // to the outputs. If it is not taken this cycle, it drops into the FIFO and
   // reappears unchanged as the head on the next cycle. That keeps the
   // outputs stable under back-pressure.
   assign bypass   = infl & fifo_empty;
   assign pop      = rsp_valid_o & rsp_ready_i;
   assign fifo_pop = pop & ~fifo_empty;
   assign push     = infl & ~(bypass & rsp_ready_i);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= infl_data;
         fifo_err[wr_ptr]  <= infl_err;
      end
   end

   // NOTE: always_comb assigns a default first, so every path writes
   // count_next and no latch is inferred.
   always_comb begin
      count_next = count;
      case ({push, fifo_pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_next;
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Responses still owed = queued + in flight. Accepting only while this is
   // below RSP_DEPTH guarantees every future push has a free slot.
   assign outstanding = {1'b0, count} + {{CW{1'b0}}, infl};
   assign req_ready_o = rst_n & (outstanding < OUT_MAX);

   assign rsp_valid_o = infl | ~fifo_empty;

   // Outputs are forced to 0 while no response is valid, so the FIFO's
   // unreset storage is never visible.
   assign data_o    = ~rsp_valid_o ? '0
                    : bypass       ? infl_data
                    :                fifo_data[rd_ptr];
   assign rsp_err_o = ~rsp_valid_o ? 1'b0
                    : bypass       ? infl_err
                    :                fifo_err[rd_ptr];

endmodule

// File: tb/tb_ram_pipe.sv
// -----------------------------------------------------------------------------
// tb_ram_pipe
//
// Bench for ram_pipe (DW=32, DP=4096, RSP_DEPTH=2).
//
// The reference model is a plain word array with per-byte "known" flags and a
// queue of owed responses:
//   - On every accepted request, one expected response is appended to the
//     queue, and writes are applied to the array.
//   - On every handshaken response, the head of the queue is popped and
//     compared with the DUT outputs.
//
// The model gives the DUT's flow control directly:
//   req_ready = rst_n && (queue size < RSP_DEPTH)
//   rsp_valid = (queue size != 0)
//
// Directed sequences pin the model with literal values. A randomized phase
// then exercises mixed traffic under random back-pressure.
// -----------------------------------------------------------------------------
module tb_ram_pipe;

   localparam int DW = 32;
   localparam int DP = 4096;
   localparam int RD = 2;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   addr = '0;
   logic          we = 1'b0;
   logic [NB-1:0] sel = '0;
   logic [DW-1:0] wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rdata;
   logic          rsp_err;

   always #5 clk = ~clk;

   ram_pipe #(.DW(DW), .DP(DP), .RSP_DEPTH(RD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .addr_i      (addr),
      .we_i        (we),
      .sel_i       (sel),
      .data_i      (wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .data_o      (rdata),
      .rsp_err_o   (rsp_err)
   );

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   typedef struct {
      logic          err;
      logic [DW-1:0] data;
      logic [DW-1:0] mask;
      int            acc;
   } rsp_t;

   rsp_t          exp_q[$];
   logic [DW-1:0] mdl [DP];
   bit   [NB-1:0] kn  [DP];

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   bit            strict_lat = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_err = 1'b0;
   bit            last_pop = 1'b0;
   bit            last_fire = 1'b0;
   logic [DW-1:0] last_data = '0;
   logic          last_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_accept();
      rsp_t        e;
      logic [31:0] widx;
      int          wi;
      widx   = addr >> $clog2(NB);
      e.err  = (widx >= 32'(DP));
      e.data = '0;
      e.mask = '1;
      e.acc  = cyc;
      wi     = int'(widx % DP);
      if (!e.err && !we) begin
         e.data = mdl[wi];
         for (int b = 0; b < NB; b++) e.mask[8*b +: 8] = kn[wi][b] ? 8'hFF : 8'h00;
      end
      if (!e.err && we) begin
         for (int b = 0; b < NB; b++) begin
            if (sel[b]) begin
               mdl[wi][8*b +: 8] = wdata[8*b +: 8];
               kn[wi][b] = 1'b1;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   // One clock cycle:
   //   1. At the falling edge, sample and check the DUT outputs against the
   //      model.
   //   2. Advance the model with the handshakes that the coming rising edge
   //      will perform.
   //   3. Return just after that rising edge, ready for new inputs.
   task automatic tick();
      rsp_t e;
      @(negedge clk);
      cyc++;
      check("req_ready", req_ready, (rst_n && exp_q.size() < RD));
      check("rsp_valid", rsp_valid, (exp_q.size() != 0));
      if (prev_stall) begin
         check("hold_data", rdata, prev_data);
         check("hold_err", rsp_err, prev_err);
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rdata;
      prev_err   = rsp_err;
      last_pop   = rsp_valid && rsp_ready;
      last_fire  = req_valid && req_ready;
      if (last_pop) begin
         last_data = rdata;
         last_err  = rsp_err;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_rsp: response with nothing owed, data %h err %b (cycle %0d)",
                     rdata, rsp_err, cyc);
         end else begin
            e = exp_q.pop_front();
            check("rsp_err", rsp_err, e.err);
            check("rsp_data", rdata & e.mask, e.data & e.mask);
            if (strict_lat) check("latency", cyc, e.acc + 1);
         end
      end
      if (last_fire) model_accept();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic w, input logic [31:0] a, input logic [NB-1:0] s,
                          input logic [DW-1:0] d);
      req_valid = 1'b1;
      we        = w;
      addr      = a;
      sel       = s;
      wdata     = d;
   endtask

   // Read request; lanes and write data are left undefined on purpose.
   task automatic set_rd(input logic [31:0] a);
      set_req(1'b0, a, 'x, 'x);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      we        = 1'b0;
   endtask

   task automatic drain();
      idle();
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int  idx;
      bit  saw_block;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_data", rdata, 0);
      check("rst_req_ready", req_ready, 0);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", req_ready, 1);
      rsp_ready = 1'b1;

      // Full-word write then read: two responses on consecutive cycles.
      set_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      tick();
      set_rd(32'h10);
      tick();
      check("t1_wr_pop", last_pop, 1);
      check("t1_wr_data", last_data, 0);
      idle();
      tick();
      check("t1_rd_pop", last_pop, 1);
      check("t1_rd_data", last_data, 32'hDEADBEEF);
      check("t1_rd_err", last_err, 0);

      // Single-lane write merges into the existing word.
      set_req(1'b1, 32'h10, 4'hF, 32'h11223344);
      tick();
      set_req(1'b1, 32'h10, 4'b0001, 32'h000000AA);
      tick();
      set_rd(32'h10);
      tick();
      idle();
      tick();
      check("t2_rd_data", last_data, 32'h112233AA);

      // Streaming: 8 writes then 8 reads, each response exactly 1 cycle later.
      strict_lat = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_req(1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA5A5A5A5 ^ (32'h01010101 * 32'(i)));
         tick();
         check("s_wr_fire", last_fire, 1);
      end
      for (int i = 0; i < 8; i++) begin
         set_rd(32'h100 + 32'(4*i));
         tick();
         check("s_rd_fire", last_fire, 1);
      end
      idle();
      tick();
      check("s_last_data", last_data, 32'hA5A5A5A5 ^ 32'h07070707);
      strict_lat = 1'b0;

      // Back-pressure: response side stalls for 5 cycles during a stream.
      idx = 0;
      saw_block = 1'b0;
      for (int c = 0; c < 40 && (idx < 8 || exp_q.size() != 0); c++) begin
         if (idx < 8) set_rd(32'h100 + 32'(4*idx));
         else idle();
         rsp_ready = !(c >= 2 && c <= 6);
         tick();
         if (last_fire) idx++;
         else if (req_valid) saw_block = 1'b1;
      end
      check("bp_all_accepted", idx, 8);
      check("bp_ready_dropped", saw_block, 1);
      drain();

      // Out-of-range accesses: error flag, zero data, and no write.
      set_req(1'b1, 32'h0, 4'hF, 32'h0BADF00D);
      tick();
      set_req(1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF);
      tick();
      set_rd(32'h4000);
      tick();
      check("oor_wr_err", last_err, 1);
      set_rd(32'h0);
      tick();
      check("oor_rd_err", last_err, 1);
      check("oor_rd_data", last_data, 0);
      idle();
      tick();
      check("w0_data", last_data, 32'h0BADF00D);
      check("w0_err", last_err, 0);

      // Reset with two responses buffered.
      rsp_ready = 1'b0;
      set_rd(32'h10);
      tick();
      tick();
      idle();
      tick();
      check("pre_rst_owed", exp_q.size(), 2);
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_req_ready", req_ready, 0);
      exp_q.delete();
      prev_stall = 1'b0;
      rsp_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rel_req_ready", req_ready, 1);
      repeat (5) tick();

      // Give every word of the random window a defined value.
      for (int i = 0; i < 64; i++) begin
         set_req(1'b1, 32'(4*i), 4'hF, $urandom);
         tick();
      end
      idle();
      tick();

      // Random mixed traffic with random back-pressure.
      for (int c = 0; c < 1500; c++) begin
         req_valid = ($urandom_range(0, 9) < 7);
         we = $urandom_range(0, 1);
         if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h4000;
         else addr = $urandom_range(0, 255);
         if (we) begin
            sel   = NB'($urandom);
            wdata = $urandom;
         end else begin
            sel   = 'x;
            wdata = 'x;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Overall time bound.
   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
